// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants for the registered 2:1 datapath multiplexer.
//   MUX_WIDTH_DEFAULT : default data width of mux_2to1 (1)
//   MUX_MAX_WIDTH     : largest legal data width (64)
//   SEL_I1 / SEL_I2   : select encodings choosing I1 / I2
//   even_parity()     : XOR-reduction helper used when MUX_PARITY_EN is defined
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam int unsigned MUX_WIDTH_DEFAULT = 1;
  localparam int unsigned MUX_MAX_WIDTH     = 64;

  localparam logic SEL_I1 = 1'b0;
  localparam logic SEL_I2 = 1'b1;

  // Even parity bit: 1 when the vector holds an odd number of ones, so that
  // data plus parity together always carry an even count. Callers zero-extend
  // narrower vectors, which leaves the result unchanged.
  function automatic logic even_parity(input logic [MUX_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage : mux_pkg

// File: rtl/mux_bit.sv
// -----------------------------------------------------------------------------
// mux_bit
// Single-bit gate-level AND-OR selector: y = (i1 & ~s) | (i2 & s).
// Ports:
//   i1_i : data bit passed when s_i = SEL_I1
//   i2_i : data bit passed when s_i = SEL_I2
//   s_i  : select
//   y_o  : selected bit (combinational)
// Built from explicit gates so an unknown select is not resolved to either
// input; it propagates through the AND terms to y_o in simulation.
// -----------------------------------------------------------------------------
module mux_bit (
  input  logic i1_i,
  input  logic i2_i,
  input  logic s_i,
  output logic y_o
);

  logic s_n;
  logic term_i1;
  logic term_i2;

  assign s_n     = ~s_i;
  assign term_i1 = i1_i & s_n;
  assign term_i2 = i2_i & s_i;
  // The two terms are mutually exclusive for a known select, so the OR never
  // merges I1 and I2 data.
  assign y_o     = term_i1 | term_i2;

endmodule : mux_bit

// File: rtl/mux_2to1.sv
// -----------------------------------------------------------------------------
// mux_2to1
// Registered 2:1 data multiplexer used as a datapath steering element.
// Optional feature macro: MUX_PARITY_EN (adds the registered R_PAR output).
// Parameters:
//   WIDTH : data width of I1, I2 and R (1..64)
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   I1    : data selected when S = SEL_I1
//   I2    : data selected when S = SEL_I2
//   S     : select line
//   V_IN  : input sample valid
//   R     : registered selected data
//   V_OUT : R was captured from a valid sample on the previous edge
//   R_PAR : even parity of R (only with MUX_PARITY_EN)
//
// Valid semantics: V_IN qualifies I1/I2/S on the same rising edge; there is no
// ready signal, so every V_IN=1 edge is accepted. V_OUT is the registered copy
// of V_IN. R (and R_PAR) update only on V_IN=1 edges and hold otherwise.
// -----------------------------------------------------------------------------
module mux_2to1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic             S,
  input  logic             V_IN,
  output logic [WIDTH-1:0] R,
`ifdef MUX_PARITY_EN
  output logic             R_PAR,
`endif
  output logic             V_OUT
);

  // Reject illegal widths when the design is elaborated.
  if (WIDTH < 1 || WIDTH > MUX_MAX_WIDTH) begin : g_bad_width
    $error("mux_2to1: WIDTH must be within 1..64");
  end

  // One AND-OR level per bit ahead of the register.
  logic [WIDTH-1:0] sel;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_bit u_bit (
      .i1_i (I1[i]),
      .i2_i (I2[i]),
      .s_i  (S),
      .y_o  (sel[i])
    );
  end

  logic [WIDTH-1:0] r_q, r_d;
  logic             v_q, v_d;

  always_comb begin
    r_d = r_q;
    v_d = V_IN;
    if (V_IN) begin
      r_d = sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      v_q <= 1'b0;
    end else begin
      r_q <= r_d;
      v_q <= v_d;
    end
  end

  assign R     = r_q;
  assign V_OUT = v_q;

`ifdef MUX_PARITY_EN
  // Parity is taken from the value being captured rather than from R, so it
  // lands on the same edge as the data it describes.
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (V_IN) begin
      par_d = even_parity(MUX_MAX_WIDTH'(sel));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign R_PAR = par_q;
`endif

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// -----------------------------------------------------------------------------
// tb_mux_2to1
// Directed bench for mux_2to1 with one WIDTH=1 and one WIDTH=8 instance
// sharing clock and reset. Inputs change 1 ns after the rising edge and
// outputs are sampled at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_mux_2to1;
  import mux_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  // ---------------- WIDTH=1 instance ----------------
  logic       a_i1, a_i2, a_s, a_v;
  logic [0:0] a_r;
  logic       a_vo;
  logic       a_par;

  mux_2to1 #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .I1    (a_i1),
    .I2    (a_i2),
    .S     (a_s),
    .V_IN  (a_v),
    .R     (a_r),
`ifdef MUX_PARITY_EN
    .R_PAR (a_par),
`endif
    .V_OUT (a_vo)
  );

  // ---------------- WIDTH=8 instance ----------------
  logic [7:0] b_i1, b_i2, b_r;
  logic       b_s, b_v, b_vo;
  logic       b_par;

  mux_2to1 #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .I1    (b_i1),
    .I2    (b_i2),
    .S     (b_s),
    .V_IN  (b_v),
    .R     (b_r),
`ifdef MUX_PARITY_EN
    .R_PAR (b_par),
`endif
    .V_OUT (b_vo)
  );

`ifndef MUX_PARITY_EN
  assign a_par = 1'b0;
  assign b_par = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Parity checks compile away when the parity port is absent.
  task automatic check_par(input string tag, input logic obs, input logic exp);
`ifdef MUX_PARITY_EN
    check(tag, {7'd0, obs}, {7'd0, exp});
`else
    if (obs !== exp) begin end
    if (tag == "") begin end
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic s, input logic i2, input logic i1, input logic v);
    a_s = s; a_i2 = i2; a_i1 = i1; a_v = v;
  endtask

  task automatic drive_b(input logic s, input logic [7:0] i2, input logic [7:0] i1, input logic v);
    b_s = s; b_i2 = i2; b_i1 = i1; b_v = v;
  endtask

  // Expected R for the 1-bit sweeps, hand-computed; index = {I2,I1}.
  logic [3:0] exp_s0;
  logic [3:0] exp_s1;
  logic [1:0] pat;

  initial begin
    exp_s0 = 4'b1010; // {11,10,01,00} -> R = I1 : 1,0,1,0
    exp_s1 = 4'b1100; // {11,10,01,00} -> R = I2 : 1,1,0,0
    drive_a(1'b0, 1'b0, 1'b0, 1'b0);
    drive_b(SEL_I1, 8'h00, 8'h00, 1'b0);

    // Reset state.
    #5;
    check("rst_r1", {7'd0, a_r}, 8'h00);
    check("rst_v1", {7'd0, a_vo}, 8'h00);
    check("rst_r8", b_r, 8'h00);
    check("rst_v8", {7'd0, b_vo}, 8'h00);
    check_par("rst_par8", b_par, 1'b0);
    tick();
    tick();
    #4 rst = 1'b0; // released between edges

    // WIDTH=1, S=0 sweep: R follows I1.
    for (int k = 0; k < 4; k++) begin
      pat = 2'(k);
      drive_a(SEL_I1, pat[1], pat[0], 1'b1);
      tick();
      check($sformatf("w1_s0_%0d_r", k), {7'd0, a_r}, {7'd0, exp_s0[k]});
      check($sformatf("w1_s0_%0d_v", k), {7'd0, a_vo}, 8'h01);
      check_par($sformatf("w1_s0_%0d_p", k), a_par, exp_s0[k]);
    end

    // WIDTH=1, S=1 sweep: R follows I2.
    for (int k = 0; k < 4; k++) begin
      pat = 2'(k);
      drive_a(SEL_I2, pat[1], pat[0], 1'b1);
      tick();
      check($sformatf("w1_s1_%0d_r", k), {7'd0, a_r}, {7'd0, exp_s1[k]});
      check($sformatf("w1_s1_%0d_v", k), {7'd0, a_vo}, 8'h01);
    end
    drive_a(SEL_I1, 1'b0, 1'b0, 1'b0);

    // WIDTH=8: toggle S every cycle with fixed I1/I2.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    for (int k = 0; k < 4; k++) begin
      drive_b(k[0] ? SEL_I2 : SEL_I1, 8'h3C, 8'hA5, 1'b1);
      tick();
      check($sformatf("tog_%0d_r", k), b_r, exp_q.pop_front());
      check($sformatf("tog_%0d_v", k), {7'd0, b_vo}, 8'h01);
      check_par($sformatf("tog_%0d_p", k), b_par, 1'b0);
    end

    // V_IN low for three cycles: R holds 3C, V_OUT drops; inputs still move.
    for (int k = 0; k < 3; k++) begin
      drive_b(k[0] ? SEL_I2 : SEL_I1, 8'hFF, 8'h11, 1'b0);
      tick();
      check($sformatf("hold_%0d_r", k), b_r, 8'h3C);
      check($sformatf("hold_%0d_v", k), {7'd0, b_vo}, 8'h00);
    end
    drive_b(SEL_I1, 8'h3C, 8'hA5, 1'b1);
    tick();
    check("resume_r", b_r, 8'hA5);
    check("resume_v", {7'd0, b_vo}, 8'h01);

    // Asynchronous reset while holding a valid FF.
    drive_b(SEL_I2, 8'hFF, 8'h00, 1'b1);
    tick();
    check("pre_rst_r", b_r, 8'hFF);
    check("pre_rst_v", {7'd0, b_vo}, 8'h01);
    #4 rst = 1'b1; // mid-cycle, no clock edge
    #1;
    check("async_rst_r", b_r, 8'h00);
    check("async_rst_v", {7'd0, b_vo}, 8'h00);
    check_par("async_rst_p", b_par, 1'b0);
    #2 rst = 1'b0;
    drive_b(SEL_I1, 8'h00, 8'h5A, 1'b1);
    tick();
    check("post_rst_r", b_r, 8'h5A);
    check("post_rst_v", {7'd0, b_vo}, 8'h01);

    // Parity of single-bit data.
    drive_b(SEL_I1, 8'h00, 8'h01, 1'b1);
    tick();
    check("par01_r", b_r, 8'h01);
    check_par("par01_p", b_par, 1'b1);
    drive_b(SEL_I2, 8'h00, 8'h01, 1'b1);
    tick();
    check("par00_r", b_r, 8'h00);
    check_par("par00_p", b_par, 1'b0);
    // Odd-weight value captured, then held with V_IN low: parity must hold too.
    drive_b(SEL_I2, 8'h07, 8'h00, 1'b1);
    tick();
    check("par07_r", b_r, 8'h07);
    check_par("par07_p", b_par, 1'b1);
    drive_b(SEL_I1, 8'h07, 8'h00, 1'b0);
    tick();
    check("par07_hold_r", b_r, 8'h07);
    check_par("par07_hold_p", b_par, 1'b1);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_2to1
